// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Drives the select of the upstream result mux and scans every input in turn.
// Each input's result goes out as an (index, data) word on a valid/ready
// stream. A one-cycle done pulse follows acceptance of the last word.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            one-cycle scan request, honoured only when idle
//   i_abort            synchronous cancel, highest priority after reset
//   o_sel              registered mux select
//   i_mux_result       combinational mux result for the current o_sel
//   o_out_data/o_out_idx/o_out_last/o_out_valid, i_out_ready  output stream
//   o_busy             scan in progress (SCAN or DRAIN)
//   o_done             one-cycle pulse when a scan completes
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start, select parked at 0
// SCAN  | sampling input o_sel, one word per accepted handshake
// DRAIN | last word captured, waiting for it to leave before done
module mux_scan_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_IN     = 5,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic [SEL_WIDTH-1:0]  o_sel,
   input  logic [DATA_WIDTH-1:0] i_mux_result,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic [SEL_WIDTH-1:0]  o_out_idx,
   output logic                  o_out_last,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_IN - 1);

   state_t                  r_state, w_state_nxt;
   logic [SEL_WIDTH-1:0]    r_sel, w_sel_nxt;
   logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
   logic [SEL_WIDTH-1:0]    r_idx, w_idx_nxt;
   logic                    r_last, w_last_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    r_done, w_done_nxt;
   logic                    w_load;
   logic                    w_slot_free;

   // The output register holds a single word; it can take a new one when it
   // is empty or its current word leaves on this edge.
   assign w_slot_free = !r_valid || i_out_ready;
   assign w_load      = (r_state == SCAN) && w_slot_free;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_data  <= '0;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_data  <= w_data_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_data_nxt  = r_data;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      w_valid_nxt = r_valid;
      w_done_nxt  = 1'b0;

      if (r_valid && i_out_ready) begin
         w_valid_nxt = 1'b0;
      end

      case (r_state)
         IDLE: begin
            w_sel_nxt = '0;
            if (i_start) begin
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (w_load) begin
               w_data_nxt  = i_mux_result;
               w_idx_nxt   = r_sel;
               w_valid_nxt = 1'b1;
               w_last_nxt  = (r_sel == LAST_SEL);
               if (r_sel < LAST_SEL) begin
                  w_sel_nxt = r_sel + SEL_WIDTH'(1);
               end else begin
                  w_sel_nxt   = '0;
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_slot_free) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
         end
      endcase

      if (i_abort) begin
         w_state_nxt = IDLE;
         w_sel_nxt   = '0;
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end

      // Busy rises with the edge that enters SCAN and stays up through the
      // edge that leaves DRAIN, so it also covers the done cycle.
      w_busy_nxt = !i_abort && ((w_state_nxt != IDLE) || (r_state != IDLE));
   end

   assign o_sel       = r_sel;
   assign o_out_data  = r_data;
   assign o_out_idx   = r_idx;
   assign o_out_last  = r_last;
   assign o_out_valid = r_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule
